// File: rtl/bin2bcd_seq.sv
// Purpose: multi-cycle binary to packed BCD converter (shift-and-add-3), one operand per handshake.
// Latency: out_valid rises WIDTH cycles after the accepting edge; WIDTH+2 cycle operand period.
// Backpressure: result held with out_valid high while out_ready=0; in_ready stays low until it is taken.
// Optional feature macro BIN2BCD_BLANK_EN adds the registered out_blank leading-zero mask.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_bcd,
   output logic                out_ovf
`ifdef BIN2BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]   out_blank
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WIDTH-1:0]    bin_sr;
   logic [4*DIGITS-1:0] bcd_sr;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_shf;
   logic                ovf_sr;
   logic                ovf_shf;
   logic [CW-1:0]       cnt;
   logic                accept;
   logic                last_iter;

   assign accept    = in_valid && (state == IDLE);
   assign last_iter = (state == SHIFT) && (cnt == CW'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; both handshakes depend on state only
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left
   always_comb begin
      bcd_adj = bcd_sr;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_sr[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
         end
      end
      bcd_shf = {bcd_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
      // A bit leaving the top digit means the operand does not fit in DIGITS digits
      ovf_shf = ovf_sr | bcd_adj[4*DIGITS-1];
   end

   // Working registers: load on accept, iterate once per SHIFT cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_sr <= '0;
         bcd_sr <= '0;
         ovf_sr <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         bin_sr <= in_data;
         bcd_sr <= '0;
         ovf_sr <= 1'b0;
         cnt    <= CW'(WIDTH);
      end else if (state == SHIFT) begin
         bin_sr <= bin_sr << 1;
         bcd_sr <= bcd_shf;
         ovf_sr <= ovf_shf;
         cnt    <= cnt - CW'(1);
      end
   end

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              hi_zero;

   // Leading-zero mask of the finished result; digit 0 is never blanked
   always_comb begin
      blank_nxt = '0;
      hi_zero   = 1'b1;
      if (!ovf_shf) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero      = hi_zero && (bcd_shf[4*i +: 4] == 4'd0);
            blank_nxt[i] = hi_zero;
         end
      end
   end
`endif

   // Result registers: captured on the final iteration, held until the next result
   always_ff @(posedge clk) begin
      if (rst) begin
         out_bcd   <= '0;
         out_ovf   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
         out_blank <= ~(DIGITS'(1));
`endif
      end else if (last_iter) begin
         out_bcd   <= bcd_shf;
         out_ovf   <= ovf_shf;
`ifdef BIN2BCD_BLANK_EN
         out_blank <= blank_nxt;
`endif
      end
   end

endmodule
